// File: rtl/data_compare4_if.sv
// Operand/cascade bus for the registered 4-bit magnitude comparator.
// The master drives both operands and the cascade input; the slave returns
// the registered GT/EQ/LT result.
interface data_compare4_if;
    logic [3:0] iData_a;   // operand A, unsigned
    logic [3:0] iData_b;   // operand B, unsigned
    logic [2:0] iData;     // cascade in: [2]=GT, [1]=EQ, [0]=LT
    logic [2:0] oData;     // registered result, same encoding

    modport master (
        output iData_a,
        output iData_b,
        output iData,
        input  oData
    );

    modport slave (
        input  iData_a,
        input  iData_b,
        input  iData,
        output oData
    );
endinterface

// File: rtl/data_compare4.sv
// Registered 4-bit unsigned magnitude comparator with cascade input, in the
// style of the 74LS85. Unequal operands decide the result directly; equal
// operands defer to the cascade input from the less-significant stage.
// One cycle of latency, no combinational path from inputs to oData.
module data_compare4 (
    input  logic           iClk,
    input  logic           iRst_n,
    data_compare4_if.slave bus
);

    logic [2:0] nextResult;
    logic [2:0] resultP0;

    // Resolve the cascade input when the local operands tie. EQ wins over
    // anything else; a lone GT or LT passes through; all-zero or GT+LT is an
    // undefined cascade and yields "no result" so the output never goes
    // multi-hot.
    function automatic logic [2:0] resolveCascade(input logic [2:0] cascade);
        logic [2:0] resolved;
        resolved = 3'b000;
        if (cascade[1]) begin
            resolved = 3'b010;
        end else if (cascade == 3'b100) begin
            resolved = 3'b100;
        end else if (cascade == 3'b001) begin
            resolved = 3'b001;
        end
        return resolved;
    endfunction

    // Combinational compare of this stage's operands.
    always_comb begin
        nextResult = 3'b000;
        if (bus.iData_a > bus.iData_b) begin
            nextResult = 3'b100;
        end else if (bus.iData_a < bus.iData_b) begin
            nextResult = 3'b001;
        end else begin
            nextResult = resolveCascade(bus.iData);
        end
    end

    // Stage 0 output register; reset has priority over the compare.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            resultP0 <= 3'b000;
        end else begin
            resultP0 <= nextResult;
        end
    end

    assign bus.oData = resultP0;

endmodule

// File: tb/tb_data_compare4.sv
// Directed self-checking bench for data_compare4.
module tb_data_compare4;

    logic iClk   = 1'b0;
    logic iRst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    data_compare4_if busIf ();

    data_compare4 dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (busIf)
    );

    always #5 iClk = ~iClk;

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        busIf.iData_a = a;
        busIf.iData_b = b;
        busIf.iData   = c;
    endtask

    task automatic stepEdge();
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        drive(4'b1111, 4'b0000, 3'b100);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b000) begin
            errors++;
            $display("FAIL reset_edge1 got %b want %b", busIf.oData, 3'b000);
        end
        drive(4'b0101, 4'b0011, 3'b010);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b000) begin
            errors++;
            $display("FAIL reset_edge2 got %b want %b", busIf.oData, 3'b000);
        end
        iRst_n = 1'b1;
        drive(4'b0010, 4'b0100, 3'b001);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b001) begin
            errors++;
            $display("FAIL reset_release got %b want %b", busIf.oData, 3'b001);
        end
    endtask

    task automatic test_magnitude(input logic [2:0] casc,
                                  input logic [3:0] aLt, input logic [3:0] bLt,
                                  input logic [3:0] aGt, input logic [3:0] bGt,
                                  input logic [3:0] aEq, input logic [2:0] eqWant);
        drive(aLt, bLt, casc);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b001) begin
            errors++;
            $display("FAIL magnitude_lt casc=%b got %b want %b", casc, busIf.oData, 3'b001);
        end
        drive(aGt, bGt, casc);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b100) begin
            errors++;
            $display("FAIL magnitude_gt casc=%b got %b want %b", casc, busIf.oData, 3'b100);
        end
        drive(aEq, aEq, casc);
        stepEdge();
        checks++;
        if (busIf.oData !== eqWant) begin
            errors++;
            $display("FAIL magnitude_eq casc=%b got %b want %b", casc, busIf.oData, eqWant);
        end
    endtask

    task automatic test_invalid_cascade();
        logic [2:0] cascVec [5] = '{3'b000, 3'b101, 3'b011, 3'b110, 3'b111};
        logic [2:0] wantVec [5] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b010};
        for (int i = 0; i < 5; i++) begin
            drive(4'b0101, 4'b0101, cascVec[i]);
            stepEdge();
            checks++;
            if (busIf.oData !== wantVec[i]) begin
                errors++;
                $display("FAIL invalid_cascade casc=%b got %b want %b",
                         cascVec[i], busIf.oData, wantVec[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [2:0] legal [3] = '{3'b100, 3'b010, 3'b001};
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] want;
        for (int c = 0; c < 3; c++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    a = ai[3:0];
                    b = bi[3:0];
                    drive(a, b, legal[c]);
                    if (ai > bi)      want = 3'b100;
                    else if (ai < bi) want = 3'b001;
                    else              want = legal[c];
                    stepEdge();
                    checks++;
                    if (busIf.oData !== want) begin
                        errors++;
                        $display("FAIL exhaustive a=%b b=%b casc=%b got %b want %b",
                                 a, b, legal[c], busIf.oData, want);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        drive(4'b1001, 4'b0001, 3'b001);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_pre got %b want %b", busIf.oData, 3'b100);
        end
        iRst_n = 1'b0;
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_clear got %b want %b", busIf.oData, 3'b000);
        end
        iRst_n = 1'b1;
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_resume got %b want %b", busIf.oData, 3'b100);
        end
    endtask

    task automatic test_no_comb_path();
        drive(4'b0111, 4'b0111, 3'b010);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b010) begin
            errors++;
            $display("FAIL comb_path_setup got %b want %b", busIf.oData, 3'b010);
        end
        drive(4'b0000, 4'b1111, 3'b001);
        #2;
        checks++;
        if (busIf.oData !== 3'b010) begin
            errors++;
            $display("FAIL comb_path_hold got %b want %b", busIf.oData, 3'b010);
        end
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b001) begin
            errors++;
            $display("FAIL comb_path_update got %b want %b", busIf.oData, 3'b001);
        end
    endtask

    task automatic test_back_to_back();
        drive(4'b1110, 4'b1101, 3'b001);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b100) begin
            errors++;
            $display("FAIL back_to_back_0 got %b want %b", busIf.oData, 3'b100);
        end
        drive(4'b1101, 4'b1110, 3'b100);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b001) begin
            errors++;
            $display("FAIL back_to_back_1 got %b want %b", busIf.oData, 3'b001);
        end
        drive(4'b1000, 4'b1000, 3'b100);
        stepEdge();
        checks++;
        if (busIf.oData !== 3'b100) begin
            errors++;
            $display("FAIL back_to_back_2 got %b want %b", busIf.oData, 3'b100);
        end
    endtask

    initial begin
        drive(4'b0000, 4'b0000, 3'b010);
        #2;
        test_reset();
        test_magnitude(3'b001, 4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b1010, 3'b001);
        test_magnitude(3'b010, 4'b0001, 4'b1000, 4'b1000, 4'b0001, 4'b1111, 3'b010);
        test_magnitude(3'b100, 4'b0011, 4'b1100, 4'b1100, 4'b0011, 4'b0110, 3'b100);
        test_invalid_cascade();
        test_no_comb_path();
        test_back_to_back();
        test_exhaustive();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
